// File: rtl/fifo_ring_pkg.sv
// Shared sizing and pointer-wrap helpers for the fifo_ring circular-buffer FIFO.
// Optional sticky error flags are enabled by defining FIFO_RING_STICKY_ERR_EN.
package fifo_ring_pkg;

    // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Explicit compare-and-wrap so non-power-of-2 depths never index past DEPTH-1.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ring_ptr.sv
// One circular-buffer pointer: increments on inc, wraps from DEPTH-1 back to 0.
module fifo_ring_ptr
    import fifo_ring_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_nxt;

    assign w_nxt = PTR_W'(ptr_next(int'(r_ptr), DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (inc)
            r_ptr <= w_nxt;
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ring.sv
// First-word fall-through FIFO over a DEPTH-entry ring; any DEPTH >= 2.
// Define FIFO_RING_STICKY_ERR_EN to latch overflow/underflow until reset.
module fifo_ring
    import fifo_ring_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 32,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int CNT_W    = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_req,
    output logic [DATA_W-1:0] r_data,
    output logic [CNT_W-1:0]  cnt,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              w_fail,
    output logic              r_fail,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign empty        = (r_cnt == '0);
    assign full         = (r_cnt == CNT_W'(DEPTH));
    assign almost_full  = (r_cnt >= CNT_W'(AF_LEVEL));
    assign almost_empty = (r_cnt <= CNT_W'(AE_LEVEL));

    // A read frees the slot in the same cycle, so a full FIFO still takes a write
    // alongside a read; when full the write slot aliases the outgoing head slot.
    assign w_wr_acc = w_req & (~full | r_req);
    assign w_rd_acc = r_req & ~empty;
    assign w_fail   = w_req & ~w_wr_acc;
    assign r_fail   = r_req & empty;

    fifo_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_acc),
        .ptr (w_wr_ptr)
    );

    fifo_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_acc),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst)
            r_mem[w_wr_ptr] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign cnt    = r_cnt;
    assign r_data = empty ? '0 : r_mem[w_rd_ptr];

`ifdef FIFO_RING_STICKY_ERR_EN
    logic r_ovf_sticky;
    logic r_unf_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            if (w_fail) r_ovf_sticky <= 1'b1;
            if (r_fail) r_unf_sticky <= 1'b1;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
    assign unf_sticky = r_unf_sticky;
`else
    assign ovf_sticky = 1'b0;
    assign unf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ring.sv
// Scoreboard bench for fifo_ring at DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
module tb_fifo_ring;

    localparam int DEPTH  = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

`ifdef FIFO_RING_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_req = 1'b0;
    logic [DATA_W-1:0] w_data = '0;
    logic              r_req = 1'b0;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  cnt;
    logic              empty, full, almost_empty, almost_full;
    logic              w_fail, r_fail, ovf_sticky, unf_sticky;

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;
    logic [DATA_W-1:0] sbq[$];

    fifo_ring #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(r_data), .cnt(cnt), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .w_fail(w_fail), .r_fail(r_fail),
        .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read must return the oldest queued word.
    always @(negedge clk) begin
        if (!rst && r_req && !empty) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no data", r_data);
            end else begin
                chk("rd_data", r_data, sbq.pop_front());
            end
        end
    end

    // One request cycle: drive, check status before the edge, then update the model.
    task automatic op(input logic w, input logic r, input logic [DATA_W-1:0] d);
        logic wacc, racc;
        @(posedge clk); #1;
        w_req = w; r_req = r; w_data = d;
        wacc = w & ((mcnt != DEPTH) | r);
        racc = r & (mcnt != 0);
        if (wacc) sbq.push_back(d);
        @(negedge clk);
        chk("cnt", 32'(cnt), 32'(mcnt));
        chk("w_fail", 32'(w_fail), 32'(w & ~wacc));
        chk("r_fail", 32'(r_fail), 32'(r & (mcnt == 0)));
        chk("empty", 32'(empty), 32'(mcnt == 0));
        chk("full", 32'(full), 32'(mcnt == 5));
        chk("almost_empty", 32'(almost_empty), 32'(mcnt <= 1));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= 4));
        mcnt = mcnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        w_req = 1'b0; r_req = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_rdata", r_data, 0);
        chk("rst_ovf", 32'(ovf_sticky), 0);
        rst = 1'b0;

        // Fill A..E, then overflow attempt
        op(1, 0, 32'h0000_000A);
        op(1, 0, 32'h0000_000B);
        op(1, 0, 32'h0000_000C);
        op(1, 0, 32'h0000_000D);
        op(1, 0, 32'h0000_000E);
        op(1, 0, 32'h0000_00FF);
        idle();
        @(negedge clk);
        chk("fill_cnt", 32'(cnt), 5);
        chk("fill_full", 32'(full), 1);
        chk("fill_head", r_data, 32'h0000_000A);
        chk("ovf_sticky_set", 32'(ovf_sticky), 32'(STICKY));

        // Drain; monitor checks A..E order
        repeat (5) op(0, 1, '0);
        idle();
        @(negedge clk);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_rdata", r_data, 0);

        // Alternating pairs wrap both pointers several times
        for (int i = 0; i < 12; i++) begin
            op(1, 0, 32'h100 + 32'(i));
            op(0, 1, '0);
        end
        idle();

        // Empty with simultaneous write/read
        op(1, 1, 32'h11);
        idle();
        @(negedge clk);
        chk("ewr_cnt", 32'(cnt), 1);
        chk("ewr_rdata", r_data, 32'h11);
        chk("unf_sticky_set", 32'(unf_sticky), 32'(STICKY));
        op(0, 1, '0);

        // Full with simultaneous write/read: head leaves, new word joins tail
        for (int i = 0; i < 5; i++) op(1, 0, 32'h200 + 32'(i));
        op(1, 1, 32'h77);
        idle();
        @(negedge clk);
        chk("fwr_cnt", 32'(cnt), 5);
        chk("fwr_head", r_data, 32'h201);
        repeat (5) op(0, 1, '0);
        idle();
        @(negedge clk);
        chk("fwr_drained", 32'(empty), 1);

        // Asynchronous reset mid-burst at cnt=3
        for (int i = 0; i < 3; i++) op(1, 0, 32'h300 + 32'(i));
        idle();
        @(negedge clk);
        chk("pre_rst_cnt", 32'(cnt), 3);
        w_req = 1'b1; w_data = 32'hDEAD;
        #1 rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_ovf", 32'(ovf_sticky), 0);
        chk("arst_unf", 32'(unf_sticky), 0);
        sbq.delete();
        mcnt = 0;
        @(posedge clk); #1;
        chk("rst_discard_cnt", 32'(cnt), 0);
        w_req = 1'b0;
        rst = 1'b0;

        // First cycle after reset works normally
        op(1, 0, 32'h55);
        op(0, 1, '0);
        idle();
        @(negedge clk);
        chk("post_rst_empty", 32'(empty), 1);
        chk("sb_leftover", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo_ring.md
FIFO_RING -- requirements
Module: fifo_ring

Interface
REQ-001 SHALL have parameter DEPTH, default 8, max element count; any integer >= 2, not restricted to powers of 2.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost_full threshold; legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 SHALL have derived parameter CNT_W = $clog2(DEPTH+1), occupancy width.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 w_req  input  1  write request.
REQ-009 w_data  input  DATA_W  write data.
REQ-010 r_req  input  1  read request, which acknowledges the word currently on r_data.
REQ-011 r_data  output  DATA_W  head word, first-word fall-through.
REQ-012 cnt  output  CNT_W  current occupancy.
REQ-013 empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-014 w_fail, r_fail  output  1 each  same-cycle rejected-request pulses.
REQ-015 ovf_sticky, unf_sticky  output  1 each  latched error flags, gated by the configuration macro.

Function
REQ-016 SHALL store data in a DEPTH-entry circular buffer addressed by write and read pointers; no shifting of stored entries.
REQ-017 Each pointer SHALL advance by 1 per accepted operation and wrap from DEPTH-1 to 0, including non-power-of-2 DEPTH.
REQ-018 A write SHALL be accepted when w_req & (~full | r_req); the word SHALL be visible on r_data 1 cycle later if the FIFO was empty.
REQ-019 A read SHALL be accepted when r_req & ~empty; r_data SHALL show the next word in the cycle after acceptance.
REQ-020 Occupancy SHALL update as: write only +1, read only -1, both accepted unchanged.
REQ-021 When empty and both requested, the SHALL result is: write accepted, read rejected, r_fail=1, cnt becomes 1.
REQ-022 When full and both requested, both SHALL be accepted, w_fail=0, and cnt stays DEPTH.
REQ-023 Flags SHALL be combinational from cnt: empty = cnt==0; full = cnt==DEPTH; almost_full = cnt>=AF_LEVEL; almost_empty = cnt<=AE_LEVEL.
REQ-024 w_fail SHALL equal w_req & ~write-accepted; r_fail SHALL equal r_req & empty; both combinational.
REQ-025 r_data SHALL be 0 while empty.
REQ-026 Rejected operations SHALL not alter pointers, cnt or storage.

Reset
REQ-027 rst SHALL asynchronously clear both pointers, cnt, ovf_sticky and unf_sticky to 0.
REQ-028 Storage contents are not reset.
REQ-029 Outputs after reset SHALL be: empty=1, almost_empty=1, full=0, almost_full=0, r_data=0.
REQ-030 An operation in the cycle rst asserts SHALL be discarded.
REQ-031 The first cycle after rst deasserts SHALL accept requests normally.

Configuration
REQ-032 With macro FIFO_RING_STICKY_ERR_EN defined, ovf_sticky SHALL set on any w_fail and unf_sticky on any r_fail, holding until rst.
REQ-033 Without FIFO_RING_STICKY_ERR_EN, ovf_sticky and unf_sticky SHALL be constant 0, and no sticky registers are synthesised.

Structure
REQ-034 Package fifo_ring_pkg SHALL hold the CNT_W computation function and a pointer-wrap helper function.
REQ-035 Sub-module fifo_ring_ptr SHALL implement one wrap-at-DEPTH pointer (inputs: clk, rst, inc; output: ptr), instantiated twice.

Verification
REQ-036 DEPTH=5: write 5 words A..E -> full=1, cnt=5; 6th write -> w_fail=1, contents unchanged; read 5 -> A..E in order, then empty=1.
REQ-037 DEPTH=5: 12 alternating write/read pairs -> pointers wrap past 4 to 0 and data order is preserved.
REQ-038 Empty with w_req=r_req=1, w_data=0x11 -> r_fail=1, cnt=1, and next cycle r_data=0x11.
REQ-039 Full with w_req=r_req=1 -> head popped, new word queued, cnt stays DEPTH, w_fail=0.
REQ-040 AF_LEVEL=4, AE_LEVEL=1: fill 0..5 -> almost_empty at cnt 0-1, almost_full at cnt 4-5.
REQ-041 rst pulsed mid-burst with cnt=3 -> cnt=0, empty=1 and stickies cleared immediately without a clock edge; with the macro, a prior overflow set ovf_sticky until that rst.
